conn_merge3: RTL and testbench



---
 rtl/conn_pkg.sv | 14 +
 rtl/conn_sync_fifo.sv | 71 +++++++
 rtl/conn_merge3.sv | 131 +++++++++++++
 tb/tb_conn_merge3.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/conn_pkg.sv
// Shared constants and types for the three-channel merge stage.
package conn_pkg;

    localparam int NCH = 3;
    localparam int DW  = 8;

    typedef logic [1:0] chan_t;

    // Successor in the 0 -> 1 -> 2 -> 0 ring; index 3 is never legal and maps back to 0.
    function automatic chan_t next_chan(input chan_t c);
        return (c >= 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

endpackage

// File: rtl/conn_sync_fifo.sv
// Per-channel synchronous FIFO with a combinational head output and an occupancy count.
module conn_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Full is taken from the registered count, so a pop on the same edge never makes room.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/conn_merge3.sv
// Merges three buffered write channels into one registered valid/ready stream
// with round-robin arbitration, source tagging and sticky per-channel drop flags.
module conn_merge3 #(
    parameter int DW    = conn_pkg::DW,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wen0,
    input  logic                  wen1,
    input  logic                  wen2,
    input  logic [DW-1:0]         data0,
    input  logic [DW-1:0]         data1,
    input  logic [DW-1:0]         data2,
    input  logic                  freeze,
    input  logic                  clear_ovf,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output conn_pkg::chan_t       out_chan,
    output logic [2:0]            overflow
);

    import conn_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NCH-1:0] wen;
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] pop;
    logic [DW-1:0]  din   [NCH];
    logic [DW-1:0]  head  [NCH];
    logic [CW-1:0]  count [NCH];

    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q,  out_data_d;
    chan_t          out_chan_q,  out_chan_d;
    chan_t          last_q,      last_d;
    logic [2:0]     ovf_q,       ovf_d;

    chan_t          grant;
    chan_t          cand;
    logic           found;
    logic           load;

    assign wen    = {wen2, wen1, wen0};
    assign din[0] = data0;
    assign din[1] = data1;
    assign din[2] = data2;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        conn_sync_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .resetn (resetn),
            .push   (wen[i]),
            .pop    (pop[i]),
            .din    (din[i]),
            .dout   (head[i]),
            .full   (full[i]),
            .empty  (empty[i]),
            .count  (count[i])
        );

        assign pop[i] = load && (grant == chan_t'(i));

        a_count_flags: assert property (@(posedge clk) disable iff (!resetn)
            (full[i] == (count[i] == CW'(DEPTH))) && (empty[i] == (count[i] == '0)));
    end

    // Walk the ring starting after the last grant; the first non-empty channel wins.
    always_comb begin
        grant = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            cand = next_chan(cand);
            if (!found && !empty[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign load = !freeze && (!out_valid_q || out_ready) && found;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = head[grant];
            out_chan_d  = grant;
            last_d      = grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // A drop on the same edge as a clear must survive the clear.
    always_comb begin
        ovf_d = (clear_ovf ? 3'b000 : ovf_q) | (wen & full);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= 2'd0;
            last_q      <= 2'd2;
            ovf_q       <= 3'b000;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_conn_merge3.sv
// Scoreboard bench for conn_merge3: expected {chan,data} pairs are queued as stimulus is
// driven and matched against every byte the downstream takes.
module tb_conn_merge3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wen0 = 1'b0, wen1 = 1'b0, wen2 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0, data2 = '0;
    logic       freeze = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_chan;
    logic [2:0] overflow;

    int         compareCount = 0;
    int         mismatchCount = 0;
    logic [9:0] sbQueue[$];
    logic [9:0] monExp;

    conn_merge3 #(.DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .wen0      (wen0),
        .wen1      (wen1),
        .wen2      (wen2),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .freeze    (freeze),
        .clear_ovf (clear_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // A byte is taken on the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_out", {22'd0, out_chan, out_data}, 32'hFFFF_FFFF);
            end else begin
                monExp = sbQueue.pop_front();
                checkOutput("out_byte", {22'd0, out_chan, out_data}, {22'd0, monExp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] w, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        wen0  = w[0];
        wen1  = w[1];
        wen2  = w[2];
        data0 = d0;
        data1 = d1;
        data2 = d2;
        tick();
        wen0 = 1'b0;
        wen1 = 1'b0;
        wen2 = 1'b0;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        sbQueue.delete();
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sbQueue.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_left", sbQueue.size(), 0);
        checkOutput("idle_after_drain", {31'd0, out_valid}, 0);
    endtask

    initial begin
        // Reset values
        tick();
        checkOutput("rst_valid", {31'd0, out_valid}, 0);
        checkOutput("rst_data", {24'd0, out_data}, 0);
        checkOutput("rst_chan", {30'd0, out_chan}, 0);
        checkOutput("rst_ovf", {29'd0, overflow}, 0);
        resetn = 1'b1;
        tick();

        // Single write on ch1: visible for exactly one cycle, one cycle after the write edge
        out_ready = 1'b1;
        sbQueue.push_back({2'd1, 8'hA5});
        applyStimulus(3'b010, 8'h00, 8'hA5, 8'h00);
        checkOutput("single_lat0", {31'd0, out_valid}, 0);
        tick();
        checkOutput("single_valid", {31'd0, out_valid}, 1);
        checkOutput("single_data", {24'd0, out_data}, 32'hA5);
        checkOutput("single_chan", {30'd0, out_chan}, 1);
        tick();
        checkOutput("single_gone", {31'd0, out_valid}, 0);
        checkOutput("single_sb", sbQueue.size(), 0);

        // Round-robin over three preloaded channels
        doReset();
        freeze = 1'b1;
        out_ready = 1'b0;
        applyStimulus(3'b111, 8'h10, 8'h20, 8'h30);
        applyStimulus(3'b111, 8'h11, 8'h21, 8'h31);
        sbQueue.push_back({2'd0, 8'h10});
        sbQueue.push_back({2'd1, 8'h20});
        sbQueue.push_back({2'd2, 8'h30});
        sbQueue.push_back({2'd0, 8'h11});
        sbQueue.push_back({2'd1, 8'h21});
        sbQueue.push_back({2'd2, 8'h31});
        freeze = 1'b0;
        out_ready = 1'b1;
        waitDrain(20);

        // Overflow on ch2: fifth byte dropped, first four delivered in order
        freeze = 1'b1;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(3'b100, 8'h00, 8'h00, 8'(i));
            if (i == 4) checkOutput("ovf_not_yet", {29'd0, overflow}, 0);
        end
        checkOutput("ovf_set", {29'd0, overflow}, 32'b100);
        for (int i = 1; i <= 4; i++) sbQueue.push_back({2'd2, 8'(i)});
        freeze = 1'b0;
        out_ready = 1'b1;
        waitDrain(20);
        checkOutput("ovf_sticky", {29'd0, overflow}, 32'b100);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checkOutput("ovf_cleared", {29'd0, overflow}, 0);

        // Backpressure: output held stable for 10 cycles, then drained without loss
        out_ready = 1'b0;
        applyStimulus(3'b011, 8'h40, 8'h50, 8'h00);
        applyStimulus(3'b001, 8'h41, 8'h00, 8'h00);
        sbQueue.push_back({2'd0, 8'h40});
        sbQueue.push_back({2'd1, 8'h50});
        sbQueue.push_back({2'd0, 8'h41});
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid", {31'd0, out_valid}, 1);
            checkOutput("bp_data", {24'd0, out_data}, 32'h40);
            checkOutput("bp_chan", {30'd0, out_chan}, 0);
            tick();
        end
        out_ready = 1'b1;
        waitDrain(20);

        // Drop into a full ch0 coinciding with clear_ovf: the set wins
        freeze = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(3'b001, 8'(8'h60 + i), 8'h00, 8'h00);
        checkOutput("sc_before", {29'd0, overflow}, 0);
        clear_ovf = 1'b1;
        applyStimulus(3'b001, 8'h64, 8'h00, 8'h00);
        clear_ovf = 1'b0;
        checkOutput("sc_set_wins", {29'd0, overflow}, 32'b001);

        // Mid-operation reset with half-full FIFOs and a pending output
        doReset();
        checkOutput("mid_ovf_rst", {29'd0, overflow}, 0);
        freeze = 1'b1;
        out_ready = 1'b0;
        applyStimulus(3'b111, 8'hA0, 8'hB0, 8'hC0);
        applyStimulus(3'b111, 8'hA1, 8'hB1, 8'hC1);
        freeze = 1'b0;
        tick();
        checkOutput("mid_pending", {31'd0, out_valid}, 1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("mid_async_valid", {31'd0, out_valid}, 0);
        checkOutput("mid_async_data", {24'd0, out_data}, 0);
        tick();
        resetn = 1'b1;
        tick();
        out_ready = 1'b1;
        sbQueue.push_back({2'd0, 8'h80});
        sbQueue.push_back({2'd1, 8'h81});
        sbQueue.push_back({2'd2, 8'h82});
        applyStimulus(3'b111, 8'h80, 8'h81, 8'h82);
        waitDrain(20);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("mid_no_stale", {31'd0, out_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
